pipeid_hazard_sb: RTL and testbench
===================================

Name: pipeid_hazard_sb

Overview:
- Parametrised hazard scoreboard for the decode stage of the pipelined CPU.
- Tracks destination-register metadata for DEPTH in-flight instructions downstream of ID.
- Generates these outputs:
  - forwarding selects for operand A, operand B and store data;
  - load-use and branch-compare stalls (PC/IR write enable);
  - IF/ID flush on redirect;
  - saturating stall counter.
- Generalises the fixed EX/MEM forwarding to configurable depth and load latency, and adds compare-in-ID hazards.

Parameters:
- RN_W, 5, register-number width.
- DEPTH, 3, tracked stages after ID (entry 0 = EX, 1 = MEM, 2 = WB, ...); minimum 1.
- LOAD_LAT, 1, entries a load must advance past before its data is forwardable (0..DEPTH-1).
- SEL_W, $clog2(DEPTH+1), forwarding-select width.
- CNT_W, 16, stall-counter width.

Ports:
- clk in 1: clock, rising edge.
- clrn in 1: asynchronous active-low reset.
- id_valid in 1: ID holds a real instruction.
- rs in RN_W: source register A.
- rt in RN_W: source register B.
- use_rs in 1: instruction reads rs.
- use_rt in 1: instruction reads rt as ALU/compare operand.
- store_rt in 1: instruction reads rt only as store data (mutually exclusive with use_rt).
- id_cmp in 1: operands are consumed in ID (beq/bne compare).
- id_wreg in 1: instruction writes a register.
- id_m2reg in 1: instruction is a load.
- id_rn in RN_W: destination register.
- id_redirect in 1: ID resolves a jump or taken branch.
- we_pc_ir out 1: PC/IR write enable (~stall).
- reset_ir out 1: squash the instruction entering ID next cycle.
- a_depen out SEL_W: 0 = regfile, k+1 = forward from entry k.
- b_depen out SEL_W: same encoding as a_depen.
- store_depen out SEL_W: same encoding as a_depen.
- stall_cnt out CNT_W: count of stall cycles.

Behaviour:
- Entry fields: valid, wreg, m2reg, rn.
- Reset (clrn=0, asynchronous): all entries valid=0; stall_cnt=0. With no dependencies the outputs are then we_pc_ir=1, all depens=0, and reset_ir=id_redirect.
- Each rising clk edge: entry[k+1] <= entry[k] for k = 0..DEPTH-2; entry[DEPTH-1] is dropped (writeback completes via the half-cycle regfile write).
- Entry 0 load: entry[0] <= {id_valid & ~stall, id_wreg, id_m2reg, id_rn}. A stall therefore inserts a bubble into EX.
- Match for source s: entry k with valid & wreg & rn==s & s!=0. The smallest k (youngest producer) wins.
- Select: sel = k+1 of the winning match, else 0. Applies only when the corresponding use flag is set; otherwise 0.
  - a_depen uses rs/use_rs.
  - b_depen uses rt/use_rt.
  - store_depen uses rt/store_rt.
- Required distance R for a matched entry k:
  - Operand A/B: R = (m2reg ? LOAD_LAT : 0) + (id_cmp ? 1 : 0).
  - Store data: R = max(0, (m2reg ? LOAD_LAT : 0) - 1), because data is needed one stage later.
  - Hazard if k < R.
- stall = id_valid & (hazard on A | hazard on B | hazard on store data).
- During a stall, the depen outputs still show the winning match; the consumer ignores them while stalled.
- we_pc_ir = ~stall. All outputs are combinational from current entries and ID inputs.
- reset_ir = id_redirect & id_valid & ~stall. A redirect during a stall is deferred until operands resolve.
- The redirecting instruction itself still enters entry 0 (jal writes r31).
- stall_cnt increments on every clock edge where stall=1 and saturates at all-ones.
- Boundaries:
  - rs or rt = 0 never produces a hazard or forward.
  - rs==rt: both operands get an identical select.
  - A producer that is both in entry k and older in entry j>k: only k is used.
  - Reset asserted mid-stall: entries are cleared immediately and the stall drops in the same cycle.

Decomposition:
- Shared package holds:
  - the entry struct {valid, wreg, m2reg, rn};
  - constant SEL_REGFILE = 0;
  - function req_dist(m2reg, cmp, is_store).
- One natural sub-module, pipeid_fwd_pick: priority match over the entries for one source, returning sel and hazard. Instantiate it three times.

Test Plan:
- ALU chain (DEPTH=3, LOAD_LAT=1): add r3 then add r4,r3,r3 next cycle -> a_depen=b_depen=1, we_pc_ir=1; one cycle later an r3 reader -> 2.
- Load-use: lw r5 followed by add r6,r5,r1 -> one stall cycle (we_pc_ir=0, bubble in entry 0), then a_depen=2, stall_cnt=1.
- Load-store: lw r5 followed by sw r5 (store_rt=1) -> no stall, store_depen=1, b_depen=0.
- Compare in ID: add r2 then beq r2,r7 with id_redirect=1 -> stall 1 cycle with reset_ir=0, then a_depen=2 and reset_ir=1. lw r2 then beq -> stall 2 cycles.
- Priority/r0: add r8 ; add r8 ; reader of r8 -> a_depen=1; writes to r0 followed by a reader of r0 -> depen=0, no stall.
- Reset during stall: assert clrn=0 while stalled -> we_pc_ir=1 immediately, stall_cnt=0, entries empty; stall_cnt saturates at 16'hFFFF under a forced long stall.

Source files
------------

// File: rtl/pipeid_hazard_sb_pkg.sv
// Shared types and helpers for the decode-stage hazard scoreboard:
// the per-stage destination record and the required-distance rule.
package pipeid_hazard_sb_pkg;

    // Register numbers are stored zero-extended to this width; RN_W must not exceed it.
    localparam int RN_W_MAX    = 8;
    localparam int SEL_REGFILE = 0;

    typedef struct packed {
        logic                valid;
        logic                wreg;
        logic                m2reg;
        logic [RN_W_MAX-1:0] rn;
    } entry_t;

    // Entries a producer must already have advanced past before its value can be used.
    // Store data is consumed one stage later than ALU operands, hence the minus one.
    function automatic int req_dist(input logic m2reg, input logic cmp,
                                    input logic is_store, input int load_lat);
        int ld;
        ld = m2reg ? load_lat : 0;
        if (is_store) begin
            return (ld > 0) ? ld - 1 : 0;
        end
        return ld + (cmp ? 1 : 0);
    endfunction

endpackage

// File: rtl/pipeid_hazard_sb_fwd_pick.sv
// Priority match of one source register against the in-flight entries;
// yields the forwarding select of the youngest producer and its hazard flag.
module pipeid_fwd_pick
    import pipeid_hazard_sb_pkg::*;
#(
    parameter int RN_W     = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = $clog2(DEPTH + 1),
    parameter bit IS_STORE = 1'b0
) (
    input  entry_t            ent_i [DEPTH],
    input  logic [RN_W-1:0]   src_i,
    input  logic              use_i,
    input  logic              cmp_i,
    output logic [SEL_W-1:0]  sel_o,
    output logic              hazard_o
);

    always_comb begin
        sel_o    = SEL_W'(SEL_REGFILE);
        hazard_o = 1'b0;
        if (use_i && (src_i != '0)) begin
            // Walk oldest to youngest so the smallest matching index is the last write.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (ent_i[k].valid && ent_i[k].wreg &&
                    (ent_i[k].rn == RN_W_MAX'(src_i))) begin
                    sel_o    = SEL_W'(k + 1);
                    hazard_o = (k < req_dist(ent_i[k].m2reg, cmp_i, IS_STORE, LOAD_LAT));
                end
            end
        end
    end

endmodule

// File: rtl/pipeid_hazard_sb.sv
// Decode-stage hazard scoreboard: shifts destination metadata down the pipe,
// produces forwarding selects, load-use/compare stalls, IF/ID flush and a stall counter.
module pipeid_hazard_sb
    import pipeid_hazard_sb_pkg::*;
#(
    parameter int RN_W     = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = $clog2(DEPTH + 1),
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              id_valid,
    input  logic [RN_W-1:0]   rs,
    input  logic [RN_W-1:0]   rt,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic              store_rt,
    input  logic              id_cmp,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic [RN_W-1:0]   id_rn,
    input  logic              id_redirect,
    output logic              we_pc_ir,
    output logic              reset_ir,
    output logic [SEL_W-1:0]  a_depen,
    output logic [SEL_W-1:0]  b_depen,
    output logic [SEL_W-1:0]  store_depen,
    output logic [CNT_W-1:0]  stall_cnt
);

    entry_t            entries_q [DEPTH];
    entry_t            entry0_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic              haz_a;
    logic              haz_b;
    logic              haz_s;
    logic              stall;

    pipeid_fwd_pick #(
        .RN_W(RN_W), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W), .IS_STORE(1'b0)
    ) u_pick_a (
        .ent_i(entries_q), .src_i(rs), .use_i(use_rs), .cmp_i(id_cmp),
        .sel_o(a_depen), .hazard_o(haz_a)
    );

    pipeid_fwd_pick #(
        .RN_W(RN_W), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W), .IS_STORE(1'b0)
    ) u_pick_b (
        .ent_i(entries_q), .src_i(rt), .use_i(use_rt), .cmp_i(id_cmp),
        .sel_o(b_depen), .hazard_o(haz_b)
    );

    pipeid_fwd_pick #(
        .RN_W(RN_W), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W), .IS_STORE(1'b1)
    ) u_pick_s (
        .ent_i(entries_q), .src_i(rt), .use_i(store_rt), .cmp_i(id_cmp),
        .sel_o(store_depen), .hazard_o(haz_s)
    );

    always_comb begin
        stall    = id_valid & (haz_a | haz_b | haz_s);
        we_pc_ir = ~stall;
        // A redirect waits until the compare operands are available.
        reset_ir = id_redirect & id_valid & ~stall;

        entry0_d       = '0;
        entry0_d.valid = id_valid & ~stall;
        entry0_d.wreg  = id_wreg;
        entry0_d.m2reg = id_m2reg;
        entry0_d.rn    = RN_W_MAX'(id_rn);

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            entries_q[0] <= entry0_d;
            for (int k = 1; k < DEPTH; k++) begin
                entries_q[k] <= entries_q[k-1];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeid_hazard_sb.sv
// Directed bench for the hazard scoreboard: a cycle-by-cycle vector table plus
// hand sequences for reset during a stall and stall-counter saturation.
module tb_pipeid_hazard_sb;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        id_valid, use_rs, use_rt, store_rt, id_cmp, id_wreg, id_m2reg, id_redirect;
    logic [4:0]  rs, rt, id_rn;
    logic        we_pc_ir, reset_ir;
    logic [1:0]  a_depen, b_depen, store_depen;
    logic [15:0] stall_cnt;
    logic        s_we, s_rir;
    logic [1:0]  s_a, s_b, s_s;
    logic [3:0]  s_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipeid_hazard_sb dut (
        .clk(clk), .clrn(clrn), .id_valid(id_valid), .rs(rs), .rt(rt),
        .use_rs(use_rs), .use_rt(use_rt), .store_rt(store_rt), .id_cmp(id_cmp),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_rn(id_rn), .id_redirect(id_redirect),
        .we_pc_ir(we_pc_ir), .reset_ir(reset_ir), .a_depen(a_depen), .b_depen(b_depen),
        .store_depen(store_depen), .stall_cnt(stall_cnt)
    );

    // Narrow counter copy so saturation is reachable in a few dozen cycles.
    pipeid_hazard_sb #(.CNT_W(4)) dut_sat (
        .clk(clk), .clrn(clrn), .id_valid(id_valid), .rs(rs), .rt(rt),
        .use_rs(use_rs), .use_rt(use_rt), .store_rt(store_rt), .id_cmp(id_cmp),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_rn(id_rn), .id_redirect(id_redirect),
        .we_pc_ir(s_we), .reset_ir(s_rir), .a_depen(s_a), .b_depen(s_b),
        .store_depen(s_s), .stall_cnt(s_cnt)
    );

    typedef struct {
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs, urt, srt, cmp, wreg, m2r;
        logic [4:0]  rn;
        logic        redir;
        logic        we, rir;
        logic [1:0]  a, b, s;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        id_valid = x.v;    rs = x.rs;       rt = x.rt;
        use_rs = x.urs;    use_rt = x.urt;  store_rt = x.srt;
        id_cmp = x.cmp;    id_wreg = x.wreg; id_m2reg = x.m2r;
        id_rn = x.rn;      id_redirect = x.redir;
    endtask

    initial begin
        //          v rs rt urs urt srt cmp wr m2r rn red | we rir a b s cnt
        tbl[0]  = '{1, 1, 2, 1, 1, 0, 0, 1, 0, 3, 0,  1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 3, 3, 1, 1, 0, 0, 1, 0, 4, 0,  1, 0, 1, 1, 0, 0};
        tbl[2]  = '{1, 3, 0, 1, 1, 0, 0, 1, 0, 9, 0,  1, 0, 2, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 1, 0, 0, 0, 1, 1, 5, 0,  1, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 5, 1, 1, 1, 0, 0, 1, 0, 6, 0,  0, 0, 1, 0, 0, 0};
        tbl[5]  = '{1, 5, 1, 1, 1, 0, 0, 1, 0, 6, 0,  1, 0, 2, 0, 0, 1};
        tbl[6]  = '{1, 1, 0, 1, 0, 0, 0, 1, 1, 5, 0,  1, 0, 0, 0, 0, 1};
        tbl[7]  = '{1, 1, 5, 1, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1};
        tbl[8]  = '{1, 1, 1, 1, 1, 0, 0, 1, 0, 2, 0,  1, 0, 0, 0, 0, 1};
        tbl[9]  = '{1, 2, 7, 1, 1, 0, 1, 0, 0, 0, 1,  0, 0, 1, 0, 0, 1};
        tbl[10] = '{1, 2, 7, 1, 1, 0, 1, 0, 0, 0, 1,  1, 1, 2, 0, 0, 2};
        tbl[11] = '{1, 1, 0, 1, 0, 0, 0, 1, 1, 2, 0,  1, 0, 0, 0, 0, 2};
        tbl[12] = '{1, 2, 7, 1, 1, 0, 1, 0, 0, 0, 1,  0, 0, 1, 0, 0, 2};
        tbl[13] = '{1, 2, 7, 1, 1, 0, 1, 0, 0, 0, 1,  0, 0, 2, 0, 0, 3};
        tbl[14] = '{1, 2, 7, 1, 1, 0, 1, 0, 0, 0, 1,  1, 1, 3, 0, 0, 4};
        tbl[15] = '{1, 1, 1, 1, 1, 0, 0, 1, 0, 8, 0,  1, 0, 0, 0, 0, 4};
        tbl[16] = '{1, 8, 1, 1, 1, 0, 0, 1, 0, 8, 0,  1, 0, 1, 0, 0, 4};
        tbl[17] = '{1, 8, 8, 1, 1, 0, 0, 1, 0, 10, 0, 1, 0, 1, 1, 0, 4};
        tbl[18] = '{1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 4};
        tbl[19] = '{1, 0, 0, 1, 1, 0, 0, 1, 0, 11, 0, 1, 0, 0, 0, 0, 4};
        tbl[20] = '{1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 4};
        tbl[21] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1,  1, 1, 0, 0, 0, 4};
        tbl[22] = '{1, 1, 0, 1, 0, 0, 0, 1, 1, 12, 0, 1, 0, 0, 0, 0, 4};
        tbl[23] = '{0, 12, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 4};
        tbl[24] = '{1, 12, 0, 1, 0, 0, 0, 1, 0, 13, 0, 1, 0, 2, 0, 0, 4};

        // Reset state: redirect passes straight through when nothing is in flight.
        drive('{1, 3, 3, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0});
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we", int'(we_pc_ir), 1);
        chk("reset_rir", int'(reset_ir), 1);
        chk("reset_a", int'(a_depen), 0);
        chk("reset_b", int'(b_depen), 0);
        chk("reset_cnt", int'(stall_cnt), 0);
        @(posedge clk);
        #1;
        clrn = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i]);
            #3;
            $display("vec %0d: we=%0d rir=%0d a=%0d b=%0d s=%0d cnt=%0d",
                     i, we_pc_ir, reset_ir, a_depen, b_depen, store_depen, stall_cnt);
            chk($sformatf("vec%0d_we", i), int'(we_pc_ir), int'(tbl[i].we));
            chk($sformatf("vec%0d_rir", i), int'(reset_ir), int'(tbl[i].rir));
            chk($sformatf("vec%0d_a", i), int'(a_depen), int'(tbl[i].a));
            chk($sformatf("vec%0d_b", i), int'(b_depen), int'(tbl[i].b));
            chk($sformatf("vec%0d_s", i), int'(store_depen), int'(tbl[i].s));
            chk($sformatf("vec%0d_cnt", i), int'(stall_cnt), int'(tbl[i].cnt));
            @(posedge clk);
            #1;
        end

        // Reset asserted in the middle of a load-use stall.
        drive(tbl[3]);
        @(posedge clk);
        #1;
        drive(tbl[4]);
        #3;
        chk("rst_stall_pre_we", int'(we_pc_ir), 0);
        chk("rst_stall_pre_cnt", int'(stall_cnt), 4);
        clrn = 1'b0;
        #1;
        $display("reset mid-stall: we=%0d a=%0d cnt=%0d", we_pc_ir, a_depen, stall_cnt);
        chk("rst_stall_we", int'(we_pc_ir), 1);
        chk("rst_stall_a", int'(a_depen), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_stall_satcnt", int'(s_cnt), 0);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        #3;
        chk("rst_after_we", int'(we_pc_ir), 1);
        chk("rst_after_a", int'(a_depen), 0);

        // Load that compares its own destination: stalls two of every three cycles.
        drive('{1, 5, 0, 1, 0, 0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0});
        for (int i = 1; i <= 30; i++) begin
            #3;
            chk($sformatf("sat%0d_we", i), int'(we_pc_ir), (i % 3 == 1) ? 1 : 0);
            @(posedge clk);
            #1;
            if (i == 21) begin
                chk("sat_cnt_pre", int'(s_cnt), 14);
            end
        end
        $display("saturation: cnt=%0d narrow_cnt=%0d", stall_cnt, s_cnt);
        chk("sat_cnt_wide", int'(stall_cnt), 20);
        chk("sat_cnt_narrow", int'(s_cnt), 15);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_cnt_hold", int'(s_cnt), 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
